// File: rtl/demux32_capture.sv
// demux32_capture
// Serial-to-parallel capture: steers each valid serial bit into position idx
// of a 32-bit shadow register and publishes the completed frame as a word
// with a one-cycle strobe. A frame_start in the middle of a frame aborts the
// partial frame and restarts it, and this abort is flagged on sync_err.
module demux32_capture (
    input  logic        clk,
    input  logic        reset,
    input  logic        bit_in,
    input  logic        bit_valid,
    input  logic        frame_start,
    output logic [31:0] word,
    output logic        word_valid,
    output logic [4:0]  idx,
    output logic        busy,
    output logic        sync_err
);

    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [4:0]  idx_q, idx_d;
    logic [31:0] shadow_q, shadow_d;
    logic [31:0] word_q, word_d;
    logic        word_valid_q, word_valid_d;
    logic        sync_err_q, sync_err_d;

    // Register all state and outputs; reset takes priority over every input.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            shadow_q     <= '0;
            word_q       <= '0;
            word_valid_q <= 1'b0;
            sync_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            shadow_q     <= shadow_d;
            word_q       <= word_d;
            word_valid_q <= word_valid_d;
            sync_err_q   <= sync_err_d;
        end
    end

    // Next-state logic: frame start, bit steering, completion and resync.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        shadow_d     = shadow_q;
        word_d       = word_q;
        word_valid_d = 1'b0;
        sync_err_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                // Only a frame_start bit opens a frame; orphan bits are dropped.
                if (bit_valid && frame_start) begin
                    shadow_d[0] = bit_in;
                    idx_d       = 5'd1;
                    state_d     = RECV;
                end
            end
            RECV: begin
                if (bit_valid) begin
                    if (frame_start) begin
                        // Abort the partial frame and restart at bit 0.
                        sync_err_d  = 1'b1;
                        shadow_d[0] = bit_in;
                        idx_d       = 5'd1;
                    end else begin
                        shadow_d[idx_q] = bit_in;
                        if (idx_q == 5'd31) begin
                            word_d       = {bit_in, shadow_q[30:0]};
                            word_valid_d = 1'b1;
                            idx_d        = '0;
                            state_d      = IDLE;
                        end else begin
                            idx_d = idx_q + 5'd1;
                        end
                    end
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
    end

    assign word       = word_q;
    assign word_valid = word_valid_q;
    assign idx        = idx_q;
    assign busy       = (state_q == RECV);
    assign sync_err   = sync_err_q;

endmodule

// File: doc/demux32_capture.md
# demux32_capture

Serial-to-parallel capture block: the receiving end of a 32:1 mux serializer whose select line is driven by a counter. It accepts one bit per valid cycle, steers it into bit position `idx` of a 32-bit shadow register (1:32 demux), and publishes the completed word with a one-cycle strobe. In the piano datapath it reassembles 32-key scan frames, key 0 first, into a parallel key-state word.

## Interface
Parameters:
- none. Word width is fixed at 32 and the index is 5 bits, matching the mux32_1 select.

Ports:
- `clk` input, 1 bit. Single clock; all state updates on the rising edge.
- `reset` input, 1 bit. Synchronous, active-high.
- `bit_in` input, 1 bit. Serial data bit, sampled only when `bit_valid`=1.
- `bit_valid` input, 1 bit. Qualifies `bit_in` for this cycle.
- `frame_start` input, 1 bit. Marks the current valid bit as bit 0 of a new frame. Meaningful only with `bit_valid`=1.
- `word` output, 32 bits. Last completed frame; bit k is the k-th received bit.
- `word_valid` output, 1 bit. One-cycle strobe: `word` was just updated.
- `idx` output, 5 bits. Position the next accepted bit will be written to.
- `busy` output, 1 bit. High while a frame is partially received.
- `sync_err` output, 1 bit. One-cycle strobe: a partial frame was aborted by a new `frame_start`.

## Operation
- Two states:
  - IDLE: waiting for a frame.
  - RECV: collecting bits.
- `busy` = (state == RECV).
- IDLE:
  - `bit_valid`=1 and `frame_start`=1: write `shadow[0]` = `bit_in`, set `idx` to 1, go to RECV.
  - `bit_valid`=1 and `frame_start`=0: bit discarded, nothing changes.
  - `frame_start` with `bit_valid`=0: ignored in all states.
- RECV, `bit_valid`=1 and `frame_start`=0:
  - Write `shadow[idx]` = `bit_in`.
  - If `idx` < 31: increment `idx`.
  - If `idx` == 31: load `word` = {`bit_in`, `shadow[30:0]`}, pulse `word_valid`, wrap `idx` to 0, go to IDLE.
- RECV, `bit_valid`=1 and `frame_start`=1 (resync mid-frame):
  - Drop the partial frame; `word` is unchanged.
  - Pulse `sync_err`.
  - Restart the frame: `shadow[0]` = `bit_in`, `idx` = 1, stay in RECV.
- RECV, `bit_valid`=0: hold. There is no timeout, and gaps of any length are allowed.
- The shadow register is never cleared between frames. Every bit of `word` is overwritten by a complete frame, so stale shadow bits never reach `word`.
- `word` holds its value until the next complete frame; it is never updated on abort.
- `sync_err` and `word_valid` are mutually exclusive, because a frame-completing bit cannot carry `frame_start`.
- Reset wins over all inputs in the cycle it is high. It forces:
  - state IDLE, `idx` = 0, `shadow` = 0
  - `word` = 0x00000000
  - `word_valid` = 0, `sync_err` = 0, `busy` = 0
- Reset mid-frame discards the partial frame without a `sync_err`.

## Timing
- All outputs are registered; there is no combinational path from inputs to outputs.
- `word` and `word_valid`: valid in the cycle after the edge that samples bit 31. Latency is 1 cycle from the last bit.
- `word_valid` and `sync_err` are high for exactly one cycle per event.
- `idx` and `busy` reflect the edge just taken. For example, after the edge sampling a `frame_start` bit, `idx`=1 and `busy`=1.
- Back-to-back frames: a `frame_start` bit in the cycle directly after bit 31 is accepted, with zero dead cycles. That cycle, `word_valid`=1 for the previous frame.
- Minimum frame length is 32 cycles. Throughput is one word per 32 valid bits.

## Test plan
- **Reset:** assert `reset` for 2 cycles with `bit_valid`=1 and `frame_start`=1 → `word`=0, `idx`=0, `busy`=0, both strobes low; no bit captured.
- **Basic frame:** send 0xA5A50F3C LSB-first, 32 consecutive valid cycles, `frame_start` on bit 0 → the cycle after bit 31: `word`=0xA5A50F3C, `word_valid` high 1 cycle, `idx`=0, `busy`=0.
- **Gapped frame:** send 0x80000001 with `bit_valid` toggling 1/0 → `word`=0x80000001 after 63 cycles; `idx` frozen during gaps.
- **Resync:** send 10 bits of a frame, then `frame_start` with 0xFFFFFFFF → `sync_err` pulses once 1 cycle after the restart; `word` keeps its prior value until the new frame completes as 0xFFFFFFFF.
- **Back-to-back and orphans:**
  - Frame 0x12345678 immediately followed by frame 0x9ABCDEF0 → two `word_valid` pulses exactly 32 cycles apart, correct words.
  - Valid bits without `frame_start` while IDLE → ignored; `idx` stays 0.
- **Mid-frame reset:** reset after 20 bits, then a full frame 0x0000FFFF → `word`=0x0000FFFF, no `sync_err`, no spurious `word_valid` from the partial frame.
